mux_arb_reg: RTL and testbench

Parametrised N-bit, CH-channel registered multiplexer with valid/ready handshakes, round-robin or fixed-priority arbitration, and an optional forced-select override. It generalises the processor's plain 2:1 datapath select into a flow-controlled stage. It sits between multiple producers (e.g. writeback sources, memory/ALU result paths) and a single consumer, and adds one register stage of latency.

---
 rtl/mux_arb_reg.sv | 100 ++++++++++
 tb/tb_mux_arb_reg.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mux_arb_reg.sv
//==============================================================================
// Module   : mux_arb_reg
// Purpose  : CH-channel, N-bit registered mux with valid/ready handshakes,
//            round-robin or fixed-priority arbitration and forced select.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mux_arb_reg #(
  parameter  int N  = 32,
  parameter  int CH = 4,
  parameter  int RR = 1,
  localparam int CW = $clog2(CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH*N-1:0] in_data,
  input  logic [CH-1:0]   in_valid,
  output logic [CH-1:0]   in_ready,
  input  logic            force_en,
  input  logic [CW-1:0]   force_sel,
  output logic [N-1:0]    out_data,
  output logic [CW-1:0]   out_ch,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [N-1:0]  r_data;
  logic [CW-1:0] r_ch;
  logic          r_valid;
  logic [CW-1:0] r_ptr;

  logic [N-1:0]  w_chan [CH];
  logic [CH-1:0] w_elig;
  logic [CH-1:0] w_grant;
  logic [CW-1:0] w_gidx;
  logic          w_any;
  logic          w_can_load;
  logic          w_xfer;

  for (genvar gi = 0; gi < CH; gi++) begin : g_chan
    assign w_chan[gi] = in_data[gi*N +: N];
  end

  // An out-of-range forced index leaves nothing eligible.
  always_comb begin
    w_elig = in_valid;
    if (force_en) begin
      w_elig = '0;
      if (32'(force_sel) < CH) w_elig[force_sel] = in_valid[force_sel];
    end
  end

  always_comb begin
    int            idx;
    logic [CW-1:0] pos;
    idx     = 0;
    pos     = '0;
    w_grant = '0;
    w_gidx  = '0;
    w_any   = 1'b0;
    for (int k = 0; k < CH; k++) begin
      idx = k + ((RR != 0) ? int'(r_ptr) : 0);
      if (idx >= CH) idx = idx - CH;
      pos = CW'(idx);
      if (!w_any && w_elig[pos]) begin
        w_any        = 1'b1;
        w_grant[pos] = 1'b1;
        w_gidx       = pos;
      end
    end
  end

  assign w_can_load = !r_valid || out_ready;
  assign w_xfer     = w_any && w_can_load && !rst;
  assign in_ready   = w_grant & {CH{w_can_load && !rst}};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_ch    <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else if (w_xfer) begin
      r_data  <= w_chan[w_gidx];
      r_ch    <= w_gidx;
      r_valid <= 1'b1;
      if (RR != 0) r_ptr <= (w_gidx == CW'(CH - 1)) ? '0 : w_gidx + 1'b1;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_data  = r_data;
  assign out_ch    = r_ch;
  assign out_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_mux_arb_reg.sv
//==============================================================================
// Module   : tb_mux_arb_reg
// Purpose  : Table-driven directed bench for mux_arb_reg (RR, fixed-priority
//            and non-power-of-two channel count instances on shared inputs).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mux_arb_reg;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic         force_en;
  logic [1:0]   force_sel;
  logic         out_ready;

  logic [3:0]   rdy_rr, rdy_fp;
  logic [2:0]   rdy_c3;
  logic [31:0]  od_rr, od_fp, od_c3;
  logic [1:0]   oc_rr, oc_fp, oc_c3;
  logic         ov_rr, ov_fp, ov_c3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_arb_reg #(.N(32), .CH(4), .RR(1)) dut_rr (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_rr), .force_en(force_en), .force_sel(force_sel),
    .out_data(od_rr), .out_ch(oc_rr), .out_valid(ov_rr), .out_ready(out_ready)
  );

  mux_arb_reg #(.N(32), .CH(4), .RR(0)) dut_fp (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_fp), .force_en(force_en), .force_sel(force_sel),
    .out_data(od_fp), .out_ch(oc_fp), .out_valid(ov_fp), .out_ready(out_ready)
  );

  mux_arb_reg #(.N(32), .CH(3), .RR(1)) dut_c3 (
    .clk(clk), .rst(rst), .in_data(in_data[95:0]), .in_valid(in_valid[2:0]),
    .in_ready(rdy_c3), .force_en(force_en), .force_sel(force_sel),
    .out_data(od_c3), .out_ch(oc_c3), .out_valid(ov_c3), .out_ready(out_ready)
  );

  typedef struct {
    int          which;   // 0 = round-robin, 1 = fixed priority, 2 = CH=3
    logic        rst;
    logic [3:0]  vld;
    logic        fen;
    logic [1:0]  fsel;
    logic        ordy;
    logic [3:0]  e_rdy;   // expected in_ready before the edge
    logic        e_ov;    // expected outputs after the edge
    logic [1:0]  e_ch;
    logic [31:0] e_data;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int w, input logic r, input logic [3:0] v,
                     input logic fe, input logic [1:0] fs, input logic orr,
                     input logic [3:0] er, input logic eov,
                     input logic [1:0] ech, input logic [31:0] ed);
    vec_t t;
    t.which = w; t.rst = r; t.vld = v; t.fen = fe; t.fsel = fs; t.ordy = orr;
    t.e_rdy = er; t.e_ov = eov; t.e_ch = ech; t.e_data = ed;
    vq.push_back(t);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hA0 + 32'(i);
    rst = 1'b1; in_valid = '0; force_en = 1'b0; force_sel = '0; out_ready = 1'b0;

    // Round-robin instance: reset, sweep, backpressure, force, wrap, reset mid-beat.
    add(0, 1, 4'hF, 0, 0, 1, 4'h0, 0, 0, 32'h0);
    add(0, 1, 4'hF, 0, 0, 1, 4'h0, 0, 0, 32'h0);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++)
        add(0, 0, 4'hF, 0, 0, 1, 4'(1 << c), 1, 2'(c), 32'hA0 + 32'(c));
    for (int s = 0; s < 3; s++)
      add(0, 0, 4'hF, 0, 0, 0, 4'h0, 1, 3, 32'hA3);
    add(0, 0, 4'hF, 0, 0, 1, 4'h1, 1, 0, 32'hA0);
    add(0, 0, 4'hF, 1, 2, 1, 4'h4, 1, 2, 32'hA2);
    add(0, 0, 4'hF, 0, 0, 1, 4'h8, 1, 3, 32'hA3);
    add(0, 0, 4'hF, 1, 2, 1, 4'h4, 1, 2, 32'hA2);
    add(0, 0, 4'h1, 0, 0, 1, 4'h1, 1, 0, 32'hA0);
    add(0, 0, 4'h3, 0, 0, 1, 4'h2, 1, 1, 32'hA1);
    add(0, 0, 4'h0, 0, 0, 1, 4'h0, 0, 1, 32'hA1);
    add(0, 0, 4'hF, 0, 0, 0, 4'h4, 1, 2, 32'hA2);
    add(0, 1, 4'hF, 0, 0, 0, 4'h0, 0, 0, 32'h0);
    add(0, 0, 4'hF, 0, 0, 1, 4'h1, 1, 0, 32'hA0);
    add(0, 0, 4'hD, 1, 1, 1, 4'h0, 0, 0, 32'hA0);
    add(0, 0, 4'hF, 0, 0, 1, 4'h2, 1, 1, 32'hA1);

    // Fixed priority: lowest valid index always wins.
    add(1, 1, 4'hF, 0, 0, 1, 4'h0, 0, 0, 32'h0);
    for (int s = 0; s < 4; s++)
      add(1, 0, 4'hA, 0, 0, 1, 4'h2, 1, 1, 32'hA1);
    add(1, 0, 4'h8, 0, 0, 1, 4'h8, 1, 3, 32'hA3);
    add(1, 0, 4'hF, 0, 0, 1, 4'h1, 1, 0, 32'hA0);
    add(1, 0, 4'hF, 1, 2, 1, 4'h4, 1, 2, 32'hA2);

    // CH=3: forced index 3 is out of range, and the pointer wraps 2 -> 0.
    add(2, 1, 4'hF, 0, 0, 1, 4'h0, 0, 0, 32'h0);
    add(2, 0, 4'hF, 0, 0, 1, 4'h1, 1, 0, 32'hA0);
    add(2, 0, 4'hF, 1, 3, 1, 4'h0, 0, 0, 32'hA0);
    add(2, 0, 4'hF, 1, 2, 1, 4'h4, 1, 2, 32'hA2);
    add(2, 0, 4'hF, 0, 0, 1, 4'h1, 1, 0, 32'hA0);

    for (int i = 0; i < vq.size(); i++) begin
      vec_t v;
      logic [3:0]  ar;
      logic        aov;
      logic [1:0]  ach;
      logic [31:0] ad;
      v = vq[i];
      rst = v.rst; in_valid = v.vld; force_en = v.fen;
      force_sel = v.fsel; out_ready = v.ordy;
      #1;
      case (v.which)
        0:       ar = rdy_rr;
        1:       ar = rdy_fp;
        default: ar = {1'b0, rdy_c3};
      endcase
      chk("in_ready", i, 32'(ar), 32'(v.e_rdy));
      @(posedge clk);
      #1;
      case (v.which)
        0:       begin aov = ov_rr; ach = oc_rr; ad = od_rr; end
        1:       begin aov = ov_fp; ach = oc_fp; ad = od_fp; end
        default: begin aov = ov_c3; ach = oc_c3; ad = od_c3; end
      endcase
      chk("out_valid", i, 32'(aov), 32'(v.e_ov));
      chk("out_ch", i, 32'(ach), 32'(v.e_ch));
      chk("out_data", i, ad, v.e_data);
    end

    // With force selecting channel 3, the CH=4 instance grants 3 while CH=3 grants nothing.
    rst = 1'b1; in_valid = 4'hF; force_en = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; force_en = 1'b1; force_sel = 2'd3;
    #1;
    chk("force3_rr_rdy", -1, 32'(rdy_rr), 32'h8);
    chk("force3_c3_rdy", -1, 32'(rdy_c3), 32'h0);
    @(posedge clk); #1;
    chk("force3_rr_ch", -1, 32'(oc_rr), 32'd3);
    chk("force3_c3_ov", -1, 32'(ov_c3), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
